// File: rtl/lcd_pkg.sv
// Shared types and constants for the 480x272 RGB565 LCD timing path.
package lcd_pkg;

   typedef logic [15:0] rgb565_t;

   localparam int DEF_H_ACTIVE = 480;
   localparam int DEF_H_FP     = 8;
   localparam int DEF_H_SYNC   = 4;
   localparam int DEF_H_BP     = 43;
   localparam int DEF_V_ACTIVE = 272;
   localparam int DEF_V_FP     = 8;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 12;

   typedef enum logic [1:0] {
      PAT_EXT   = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_GRAD  = 2'd3
   } pat_mode_e;

   localparam rgb565_t C_WHITE   = 16'hFFFF;
   localparam rgb565_t C_YELLOW  = 16'hFFE0;
   localparam rgb565_t C_CYAN    = 16'h07FF;
   localparam rgb565_t C_GREEN   = 16'h07E0;
   localparam rgb565_t C_MAGENTA = 16'hF81F;
   localparam rgb565_t C_RED     = 16'hF800;
   localparam rgb565_t C_BLUE    = 16'h001F;
   localparam rgb565_t C_BLACK   = 16'h0000;

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational test-pattern source: pattern mode and pixel coordinate to RGB565.
module lcd_pattern_gen
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE
) (
   input  pat_mode_e  mode_i,
   input  logic [8:0] x_i,
   input  logic [8:3] y_hi_i,
   output rgb565_t    rgb_o
);
   localparam int BAR_W = H_ACTIVE / 8;

   rgb565_t bar;

   // Comparator chain keeps the bar index free of a divider.
   always_comb begin
      bar = C_BLACK;
      if      (int'(x_i) < 1 * BAR_W) bar = C_WHITE;
      else if (int'(x_i) < 2 * BAR_W) bar = C_YELLOW;
      else if (int'(x_i) < 3 * BAR_W) bar = C_CYAN;
      else if (int'(x_i) < 4 * BAR_W) bar = C_GREEN;
      else if (int'(x_i) < 5 * BAR_W) bar = C_MAGENTA;
      else if (int'(x_i) < 6 * BAR_W) bar = C_RED;
      else if (int'(x_i) < 7 * BAR_W) bar = C_BLUE;
   end

   always_comb begin
      rgb_o = '0;
      case (mode_i)
         PAT_BARS:  rgb_o = bar;
         PAT_CHECK: rgb_o = (x_i[4] ^ y_hi_i[4]) ? C_WHITE : C_BLACK;
         PAT_GRAD:  rgb_o = {x_i[8:4], y_hi_i, 5'd0};
         default:   rgb_o = '0;
      endcase
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parallel RGB LCD timing: stage-0 h/v counters, stage-1 pixel request,
// stage-2 mutually aligned HSYNC/VSYNC/DE/RGB pins.
module lcd_timing_gen
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [1:0]  mode_i,
   input  logic [15:0] pix_data_i,
   output logic        pix_req_o,
   output logic [8:0]  pix_x_o,
   output logic [8:0]  pix_y_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        de_o,
   output logic [15:0] rgb_o,
   output logic        frame_start_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
   localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          h_act, v_act, h_sync, v_sync, origin;
   pat_mode_e     mode_q, mode2_q;
   logic          req1_q, hs1_q, vs1_q, fs1_q;
   logic [8:0]    x1_q, y1_q;
   logic          de_q, hs2_q, vs2_q, fs2_q;
   rgb565_t       pat, pat_q;

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (!en_i) begin
         h_d = '0;
         v_d = '0;
      end else if (h_q == HW'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end else begin
         h_d = h_q + HW'(1);
      end
   end

   assign h_act  = h_q < HW'(H_ACTIVE);
   assign v_act  = v_q < VW'(V_ACTIVE);
   assign h_sync = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign v_sync = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign origin = (h_q == '0) && (v_q == '0);

   // Mode only changes at the frame origin so a frame never mixes two patterns.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         h_q    <= '0;
         v_q    <= '0;
         mode_q <= pat_mode_e'(mode_i);
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         if (origin) mode_q <= pat_mode_e'(mode_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         req1_q <= 1'b0;
         x1_q   <= '0;
         y1_q   <= '0;
         hs1_q  <= 1'b0;
         vs1_q  <= 1'b0;
         fs1_q  <= 1'b0;
      end else begin
         req1_q <= h_act && v_act;
         x1_q   <= (h_act && v_act) ? h_q[8:0] : '0;
         y1_q   <= (h_act && v_act) ? v_q[8:0] : '0;
         hs1_q  <= h_sync;
         vs1_q  <= v_sync;
         fs1_q  <= origin;
      end
   end

   lcd_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pat (
      .mode_i (mode_q),
      .x_i    (x1_q),
      .y_hi_i (y1_q[8:3]),
      .rgb_o  (pat)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         de_q    <= 1'b0;
         hs2_q   <= ~SYNC_POL;
         vs2_q   <= ~SYNC_POL;
         fs2_q   <= 1'b0;
         pat_q   <= '0;
         mode2_q <= PAT_EXT;
      end else begin
         de_q    <= req1_q;
         hs2_q   <= hs1_q ? SYNC_POL : ~SYNC_POL;
         vs2_q   <= vs1_q ? SYNC_POL : ~SYNC_POL;
         fs2_q   <= fs1_q;
         pat_q   <= req1_q ? pat : '0;
         mode2_q <= mode_q;
      end
   end

   // External pixels arrive one cycle after the request, i.e. already aligned with de_q.
   assign rgb_o = !de_q ? '0 : ((mode2_q == PAT_EXT) ? pix_data_i : pat_q);

   assign pix_req_o     = req1_q;
   assign pix_x_o       = x1_q;
   assign pix_y_o       = y1_q;
   assign hsync_o       = hs2_q;
   assign vsync_o       = vs2_q;
   assign de_o          = de_q;
   assign frame_start_o = fs2_q;

endmodule
